// File: rtl/lorenz_plot_reader.sv
// Decimates the Lorenz x/z stream and projects samples to 640x480 pixels.
// Optional build macro LORENZ_PLOT_ZCOLOR_EN colours pixels by z height.
module lorenz_plot_reader #(
    parameter int          X_CENTER = 320,
    parameter int          Y_BASE   = 479,
    parameter int          SHIFT    = 17,
    parameter logic [7:0]  COLOR    = 8'h1C
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [26:0] x_in,
    input  logic signed [26:0] z_in,
    input  logic               run,
    input  logic [15:0]        decim,
    output logic [9:0]         pix_x,
    output logic [8:0]         pix_y,
    output logic [7:0]         pix_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        clip_cnt,
    output logic [31:0]        pix_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;

    state_t             state;
    logic [15:0]        dcnt;
    logic [15:0]        dterm;
    logic signed [11:0] xs;
    logic signed [11:0] zs;
    logic signed [11:0] px;
    logic signed [11:0] py;
    logic               in_range;
    logic               capture;
    logic               accept;
    logic               load;
    logic [7:0]         color;

    assign dterm = (decim == 16'd0) ? 16'd0 : decim - 16'd1;

    // Projection is deliberately done in 12-bit signed arithmetic.
    assign xs = 12'(x_in >>> SHIFT);
    assign zs = 12'(z_in >>> SHIFT);
    assign px = 12'(X_CENTER) + xs;
    assign py = 12'(Y_BASE) - zs;

    assign in_range = (px >= 12'sd0) && (px <= 12'sd639) &&
                      (py >= 12'sd0) && (py <= 12'sd479);

`ifdef LORENZ_PLOT_ZCOLOR_EN
    assign color = z_in[26] ? 8'h03 : {z_in[25:20], 2'b11};
`else
    assign color = COLOR;
`endif

    assign capture = run && (state != IDLE) && (dcnt == dterm);
    assign accept  = (state == EMIT) && pix_ready;
    assign load    = capture && in_range &&
                     ((state == WAIT) || pix_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dcnt      <= 16'd0;
            pix_x     <= 10'd0;
            pix_y     <= 9'd0;
            pix_color <= 8'd0;
            pix_valid <= 1'b0;
            drop_cnt  <= 16'd0;
            clip_cnt  <= 16'd0;
            pix_cnt   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    dcnt <= 16'd0;
                    if (run)
                        state <= WAIT;
                end
                default: begin
                    dcnt <= capture ? 16'd0 : dcnt + 16'd1;
                    if (capture && !in_range && clip_cnt != 16'hFFFF)
                        clip_cnt <= clip_cnt + 16'd1;
                    if (accept)
                        pix_cnt <= pix_cnt + 32'd1;
                    if (load) begin
                        pix_x     <= px[9:0];
                        pix_y     <= py[8:0];
                        pix_color <= color;
                        pix_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (capture && in_range) begin
                        if (drop_cnt != 16'hFFFF)
                            drop_cnt <= drop_cnt + 16'd1;
                    end else if (accept) begin
                        pix_valid <= 1'b0;
                        state     <= run ? WAIT : IDLE;
                    end else if (state == WAIT && !run) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lorenz_plot_reader.sv
// Directed self-checking bench for lorenz_plot_reader.
// Each scenario task drives vectors and checks hand-computed results.
module tb_lorenz_plot_reader;

    logic               clk;
    logic               reset;
    logic signed [26:0] x_in;
    logic signed [26:0] z_in;
    logic               run;
    logic [15:0]        decim;
    logic [9:0]         pix_x;
    logic [8:0]         pix_y;
    logic [7:0]         pix_color;
    logic               pix_valid;
    logic               pix_ready;
    logic [15:0]        drop_cnt;
    logic [15:0]        clip_cnt;
    logic [31:0]        pix_cnt;

    int n_checks;
    int n_fail;

`ifdef LORENZ_PLOT_ZCOLOR_EN
    localparam logic [7:0] EXP_COLOR = 8'h67;
`else
    localparam logic [7:0] EXP_COLOR = 8'h1C;
`endif

    localparam logic signed [26:0] ONE     = 27'sh0100000;
    localparam logic signed [26:0] NEG_ONE = 27'sh7F00000;

    lorenz_plot_reader dut (
        .clk(clk),
        .reset(reset),
        .x_in(x_in),
        .z_in(z_in),
        .run(run),
        .decim(decim),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_color(pix_color),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .drop_cnt(drop_cnt),
        .clip_cnt(clip_cnt),
        .pix_cnt(pix_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        run   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        x_in = '0; z_in = '0; decim = 16'd1; pix_ready = 1'b0;
        apply_reset();
        n_checks++;
        if ({pix_valid, pix_x, pix_y, pix_color} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_pix: got v=%0b x=%0d y=%0d c=%h want all 0",
                     pix_valid, pix_x, pix_y, pix_color);
        end
        n_checks++;
        if ({drop_cnt, clip_cnt, pix_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got d=%0d c=%0d p=%0d want 0",
                     drop_cnt, clip_cnt, pix_cnt);
        end
    endtask

    task automatic test_basic;
        apply_reset();
        x_in = NEG_ONE; z_in = 27'sh1900000;
        decim = 16'd1; pix_ready = 1'b1; run = 1'b1;
        tick();
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency1: got v=%0b want 0", pix_valid);
        end
        tick();
        n_checks++;
        if (pix_valid !== 1'b1 || pix_x !== 10'd312 || pix_y !== 9'd279 ||
            pix_color !== EXP_COLOR) begin
            n_fail++;
            $display("FAIL basic_pixel: got v=%0b x=%0d y=%0d c=%h want 1 312 279 %h",
                     pix_valid, pix_x, pix_y, pix_color, EXP_COLOR);
        end
    endtask

    task automatic test_decimation;
        int          k;
        logic [31:0] p0;
        apply_reset();
        x_in = '0; z_in = '0; decim = 16'd4; pix_ready = 1'b1; run = 1'b1;
        k = 0;
        while (pix_valid !== 1'b1 && k < 20) begin tick(); k++; end
        n_checks++;
        if (pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL decim_first: no pixel within 20 cycles");
        end
        p0 = pix_cnt;
        repeat (400) tick();
        n_checks++;
        if (pix_cnt - p0 !== 32'd100 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL decim4: got dpix=%0d drop=%0d want 100 0",
                     pix_cnt - p0, drop_cnt);
        end
        k = 0;
        while (pix_valid !== 1'b1 && k < 20) begin tick(); k++; end
        decim = 16'd0;
        p0 = pix_cnt;
        repeat (10) tick();
        n_checks++;
        if (pix_cnt - p0 !== 32'd10) begin
            n_fail++;
            $display("FAIL decim0: got dpix=%0d want 10", pix_cnt - p0);
        end
    endtask

    task automatic test_clip;
        apply_reset();
        x_in = 27'sh2D00000; z_in = '0;
        decim = 16'd1; pix_ready = 1'b1; run = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (clip_cnt !== 16'd4 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_x: got clip=%0d v=%0b want 4 0",
                     clip_cnt, pix_valid);
        end
        x_in = '0; z_in = NEG_ONE;
        repeat (3) tick();
        n_checks++;
        if (clip_cnt !== 16'd7 || pix_valid !== 1'b0 || pix_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL clip_z: got clip=%0d v=%0b p=%0d want 7 0 0",
                     clip_cnt, pix_valid, pix_cnt);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        apply_reset();
        x_in = '0; z_in = '0;
        decim = 16'd2; pix_ready = 1'b0; run = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (pix_valid !== 1'b1 || pix_x !== 10'd320 || pix_y !== 9'd479) begin
            n_fail++;
            $display("FAIL bp_first: got v=%0b x=%0d y=%0d want 1 320 479",
                     pix_valid, pix_x, pix_y);
        end
        x_in = ONE;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (pix_valid !== 1'b1 || pix_x !== 10'd320) bad++;
        end
        n_checks++;
        if (bad != 0 || drop_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_hold: got unstable=%0d drop=%0d want 0 4",
                     bad, drop_cnt);
        end
        pix_ready = 1'b1;
        tick();
        n_checks++;
        if (pix_cnt !== 32'd1 || pix_x !== 10'd328 || drop_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_accept: got p=%0d x=%0d drop=%0d want 1 328 4",
                     pix_cnt, pix_x, drop_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        apply_reset();
        x_in = '0; z_in = '0;
        decim = 16'd1; pix_ready = 1'b1; run = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            x_in = 27'(i) <<< 20;
            tick();
            if (pix_valid !== 1'b1 || pix_x !== 10'(320 + 8 * i)) begin
                bad++;
                $display("FAIL b2b_pix%0d: got v=%0b x=%0d want 1 %0d",
                         i, pix_valid, pix_x, 320 + 8 * i);
            end
        end
        n_checks++;
        if (bad != 0 || drop_cnt !== 16'd0 || pix_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL b2b: got bad=%0d drop=%0d p=%0d want 0 0 7",
                     bad, drop_cnt, pix_cnt);
        end
    endtask

    task automatic test_run_drop;
        int bad;
        pix_ready = 1'b0; run = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            x_in = 27'(i) <<< 20;
            tick();
            if (pix_valid !== 1'b1 || pix_x !== 10'd376) bad++;
        end
        n_checks++;
        if (bad != 0 || pix_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL rundrop_hold: got unstable=%0d p=%0d want 0 7",
                     bad, pix_cnt);
        end
        pix_ready = 1'b1;
        tick();
        repeat (5) tick();
        n_checks++;
        if (pix_valid !== 1'b0 || pix_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL rundrop_idle: got v=%0b p=%0d want 0 8",
                     pix_valid, pix_cnt);
        end
        pix_ready = 1'b0; run = 1'b1;
        tick();
        tick();
        n_checks++;
        if (pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun: got v=%0b want 1", pix_valid);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (pix_valid !== 1'b0 || {drop_cnt, clip_cnt, pix_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_emit: got v=%0b d=%0d c=%0d p=%0d want 0",
                     pix_valid, drop_cnt, clip_cnt, pix_cnt);
        end
        reset = 1'b0; run = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; run = 1'b0; decim = 16'd1;
        x_in = '0; z_in = '0; pix_ready = 1'b0;
        test_reset();
        test_basic();
        test_decimation();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_run_drop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lorenz_plot_reader.md
# lorenz_plot_reader

Consumes the free-running 7.20 fixed-point Lorenz state stream (x, y, z) produced by the integrator. It decimates the stream and projects each kept sample onto the x–z plane as a 640×480 pixel coordinate. It then hands each pixel to the VGA/SRAM pixel writer over a valid/ready handshake. It sits between the integrator outputs and the pixel writer, and it counts samples lost to clipping or back-pressure.

## Interface
Parameters:
- `X_CENTER`, default 320: screen column for x = 0.
- `Y_BASE`, default 479: screen row for z = 0.
- `SHIFT`, default 17: arithmetic right shift applied to 7.20 values. 17 gives 8 pixels per unit.
- `COLOR`, default 8'h1C: constant RGB332 colour, used when `LORENZ_PLOT_ZCOLOR_EN` is undefined.

Ports:
- `clk`  in  1  system clock (clk_50 domain).
- `reset`  in  1  synchronous, active-high reset.
- `x_in`  in  27 signed  integrator x state, 7.20 two's complement.
- `z_in`  in  27 signed  integrator z state, 7.20 two's complement.
- `run`  in  1  level; enables sampling.
- `decim`  in  16  decimation ratio. One sample is kept every `decim` cycles; 0 is treated as 1.
- `pix_x`  out  10  pixel column, 0..639.
- `pix_y`  out  9  pixel row, 0..479.
- `pix_color`  out  8  RGB332 colour.
- `pix_valid`  out  1  pixel offered.
- `pix_ready`  in  1  pixel writer accepts.
- `drop_cnt`  out  16  saturating count of samples lost to back-pressure.
- `clip_cnt`  out  16  saturating count of samples outside the screen.
- `pix_cnt`  out  32  wrapping count of accepted pixels.

## Operation
States:
- IDLE: entered from reset, or when `run` is low and no pixel is pending.
- WAIT: counting toward the next capture.
- EMIT: `pix_valid` is high.

Decimation counter `dcnt` (16 bits):
- Cleared in IDLE.
- In WAIT and EMIT it increments each cycle.
- A capture occurs when `dcnt == max(decim,1)-1`. `dcnt` returns to 0 on that cycle.

Projection, computed in signed 12-bit arithmetic from the `x_in`/`z_in` values present on the capture cycle:
- `px = X_CENTER + (x_in >>> SHIFT)`
- `py = Y_BASE - (z_in >>> SHIFT)`
- The sample is in range iff 0 ≤ px ≤ 639 and 0 ≤ py ≤ 479.
- An out-of-range sample increments `clip_cnt` and is discarded. No state change results.

Capture handling:
- In-range capture while in WAIT: load `pix_x`/`pix_y`/`pix_color`, then go to EMIT.
- In-range capture while in EMIT, with `pix_ready` low that cycle: increment `drop_cnt`. The held pixel is kept unchanged.
- In-range capture while in EMIT, with `pix_ready` high the same cycle: the old pixel is accepted and the new one is loaded. The block stays in EMIT. No drop is counted.

Handshake rules:
- In EMIT, `pix_x`/`pix_y`/`pix_color` are stable and `pix_valid` stays high until a cycle with `pix_ready` high.
- On that acceptance cycle, `pix_cnt` increments and the state returns to WAIT, unless a new load occurs the same cycle.
- `pix_valid` never drops without acceptance.

Run control:
- `run` low in WAIT: go to IDLE next cycle.
- `run` low in EMIT: complete the pending handshake, then go to IDLE. No new captures are taken while `run` is low.
- `run` high in IDLE: go to WAIT, with `dcnt` = 0.

`decim` is sampled continuously. Changing it mid-count takes effect against the current `dcnt`. If `dcnt` is already past the new terminal value, the counter wraps through 65535 before reaching it.

Counters:
- `drop_cnt` and `clip_cnt` saturate at 16'hFFFF.
- `pix_cnt` wraps at 2^32.

## Timing
- Reset values: `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_color`=0, `drop_cnt`=0, `clip_cnt`=0, `pix_cnt`=0, state IDLE, `dcnt`=0.
- Reset asserted mid-EMIT drops the pending pixel immediately, with no acceptance.
- Latency: `pix_valid` and the pixel fields are registered and appear the cycle after the capture cycle.
- The first capture after `run` rises occurs `max(decim,1)` cycles after entry to WAIT.
- Throughput: with `decim`=1 and `pix_ready` held high, one pixel is accepted every cycle.
- All outputs are registered. There is no combinational path from `pix_ready` to `pix_valid`.

## Configuration
- `LORENZ_PLOT_ZCOLOR_EN` defined: `pix_color = {z_in[25:20], 2'b11}` when `z_in` ≥ 0, and 8'h03 when `z_in` < 0.
- `LORENZ_PLOT_ZCOLOR_EN` undefined: `pix_color = COLOR` for every pixel.
- Handshake and timing are identical in both builds.

## Test plan
- Basic pixel: reset, then `run`=1, `decim`=1, `pix_ready`=1, with `x_in`=−1.0 (27'h7F00000) and `z_in`=25.0 (27'h1900000). Required: `pix_x`=312, `pix_y`=279, `pix_color`=8'h67 with the macro and 8'h1C without it. `pix_valid` goes high 2 cycles after `run` rises.
- Decimation: `decim`=4, `pix_ready`=1, held 400 cycles after the first capture. Required: `pix_cnt` = 100 and `drop_cnt` = 0. Then `decim`=0 for 10 cycles: `pix_cnt` advances by 10.
- Clipping: `x_in`=+45.0 gives px = 680. Required: `clip_cnt` increments once per capture and `pix_valid` stays 0. Repeat with `z_in`=−1.0 (py = 487): the same clip behaviour is required.
- Back-pressure: `decim`=2, `pix_ready`=0 for 9 cycles, then 1. Required: the first pixel is held stable throughout, `drop_cnt`=4, and `pix_cnt`=1 after acceptance.
- Simultaneous accept and capture: `decim`=1, `pix_ready`=1, with `x_in` changing every cycle. Required: `pix_valid` stays continuously high, a new `pix_x` appears every cycle, and `drop_cnt`=0.
- Run drop and reset: drop `run` during EMIT with `pix_ready`=0 for 3 cycles. Required: `pix_valid` stays high until acceptance, then the block goes to IDLE with no further pixels. Then assert `reset` mid-EMIT: `pix_valid`=0 and all counters are 0 on the next cycle.
